// File: rtl/wb_route_pkg.sv
// Shared encodings and types for the write-back route queue.
package wb_route_pkg;
    localparam logic [1:0] DEST_0 = 2'd0;
    localparam logic [1:0] DEST_1 = 2'd1;
    localparam logic [1:0] DEST_2 = 2'd2;
    localparam logic [1:0] DEST_3 = 2'd3;

    localparam int NUM_DEST = 4;
    localparam int STAT_W   = 16;

    typedef logic [STAT_W-1:0] stat_t;
endpackage

// File: rtl/wb_route_queue_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter
    import wb_route_pkg::*;
#(
    parameter int W = STAT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/wb_route_queue.sv
// Circular queue of (data, dest select) pairs feeding a 1-to-4 demux.
// Optional per-destination delivery counters with `WB_ROUTE_STATS_EN.
module wb_route_queue
    import wb_route_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic             in_ready,
    input  logic             flush,
    input  logic [3:0]       dest_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    output logic [CW-1:0]    count
`ifdef WB_ROUTE_STATS_EN
    ,
    output logic [63:0]      stat_cnt
`endif
);
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [1:0]       sel_mem  [DEPTH];
    logic [WIDTH-1:0] head_data;
    logic [1:0]       head_sel;
    logic             push, pop;

    assign head_data = data_mem[rptr];
    assign head_sel  = sel_mem[rptr];

    // in_ready looks only at occupancy: a full queue refuses even while popping
    assign in_ready  = (cnt < CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign out_data  = out_valid ? head_data : '0;
    assign out_sel   = out_valid ? head_sel  : DEST_0;
    assign count     = cnt;

    // flush overrides both sides so a flushed entry is never delivered
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & dest_ready[head_sel] & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wptr] <= in_data;
            sel_mem[wptr]  <= in_sel;
        end
    end

`ifdef WB_ROUTE_STATS_EN
    logic [NUM_DEST-1:0][STAT_W-1:0] stat_q;

    for (genvar k = 0; k < NUM_DEST; k++) begin : g_stat
        sat_counter #(.W(STAT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (pop && (head_sel == 2'(k))),
            .cnt   (stat_q[k])
        );
    end

    assign stat_cnt = stat_q;
`endif
endmodule

// File: tb/tb_wb_route_queue.sv
// Directed vector bench for wb_route_queue (stats checks with `WB_ROUTE_STATS_EN).
module tb_wb_route_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_ready;
    logic        flush;
    logic [3:0]  dest_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic [2:0]  count;
`ifdef WB_ROUTE_STATS_EN
    logic [63:0] stat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_route_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .flush      (flush),
        .dest_ready (dest_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .count      (count)
`ifdef WB_ROUTE_STATS_EN
        ,
        .stat_cnt   (stat_cnt)
`endif
    );

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic [1:0]  is;
        logic        fl;
        logic [3:0]  dr;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  es;
        logic [2:0]  ec;
        logic        er;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic iv, input logic [31:0] id, input logic [1:0] is,
                       input logic fl, input logic [3:0] dr, input logic ev,
                       input logic [31:0] ed, input logic [1:0] es,
                       input logic [2:0] ec, input logic er);
        vec_t v;
        v.iv = iv; v.id = id; v.is = is; v.fl = fl; v.dr = dr;
        v.ev = ev; v.ed = ed; v.es = es; v.ec = ec; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ev, input logic [31:0] ed,
                            input logic [1:0] es, input logic [2:0] ec, input logic er);
        chk({tag, " out_valid"}, 64'(out_valid), 64'(ev));
        chk({tag, " out_data"},  64'(out_data),  64'(ed));
        chk({tag, " out_sel"},   64'(out_sel),   64'(es));
        chk({tag, " count"},     64'(count),     64'(ec));
        chk({tag, " in_ready"},  64'(in_ready),  64'(er));
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic [1:0] is,
                         input logic fl, input logic [3:0] dr);
        in_valid = iv; in_data = id; in_sel = is; flush = fl; dest_ready = dr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 4'b0000);

        // ordered delivery
        add(1, 32'hA, 2, 0, 4'b1111, 1, 32'hA, 2, 1, 1);
        add(1, 32'hB, 0, 0, 4'b1111, 1, 32'hB, 0, 1, 1);
        add(0, 0,     0, 0, 4'b1111, 0, 0,     0, 0, 1);
        // head-of-line block: only destination 1 ready while head wants 3
        add(1, 32'h1, 3, 0, 4'b0010, 1, 32'h1, 3, 1, 1);
        add(1, 32'h2, 1, 0, 4'b0010, 1, 32'h1, 3, 2, 1);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 0, 4'b0010, 1, 32'h1, 3, 2, 1);
        add(0, 0, 0, 0, 4'b1000, 1, 32'h2, 1, 1, 1);
        add(0, 0, 0, 0, 4'b1010, 0, 0,     0, 0, 1);
        // fill, refuse fifth push, partial drain, wrap refill
        add(1, 32'h10, 0, 0, 4'b0000, 1, 32'h10, 0, 1, 1);
        add(1, 32'h11, 1, 0, 4'b0000, 1, 32'h10, 0, 2, 1);
        add(1, 32'h12, 2, 0, 4'b0000, 1, 32'h10, 0, 3, 1);
        add(1, 32'h13, 3, 0, 4'b0000, 1, 32'h10, 0, 4, 0);
        add(1, 32'h14, 0, 0, 4'b0000, 1, 32'h10, 0, 4, 0);
        add(0, 0,      0, 0, 4'b0001, 1, 32'h11, 1, 3, 1);
        add(0, 0,      0, 0, 4'b0010, 1, 32'h12, 2, 2, 1);
        add(1, 32'h15, 1, 0, 4'b0000, 1, 32'h12, 2, 3, 1);
        add(1, 32'h16, 0, 0, 4'b0000, 1, 32'h12, 2, 4, 0);
        // full with head ready: pop happens, push refused
        add(1, 32'h17, 3, 0, 4'b0100, 1, 32'h13, 3, 3, 1);
        add(0, 0,      0, 0, 4'b1000, 1, 32'h15, 1, 2, 1);
        add(0, 0,      0, 0, 4'b0010, 1, 32'h16, 0, 1, 1);
        add(0, 0,      0, 0, 4'b0001, 0, 0,      0, 0, 1);
        // flush with push and pop attempted in the same cycle
        add(1, 32'h20, 0, 0, 4'b0000, 1, 32'h20, 0, 1, 1);
        add(1, 32'h21, 1, 0, 4'b0000, 1, 32'h20, 0, 2, 1);
        add(1, 32'h22, 2, 0, 4'b0000, 1, 32'h20, 0, 3, 1);
        add(1, 32'h23, 3, 1, 4'b1111, 0, 0,      0, 0, 1);
        add(0, 0,      0, 0, 4'b1111, 0, 0,      0, 0, 1);

        #12;
        chk_outs("reset", 0, 0, 0, 0, 1);
`ifdef WB_ROUTE_STATS_EN
        chk("reset stat_cnt", stat_cnt, 64'h0);
`endif
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].is, tbl[i].fl, tbl[i].dr);
            tick();
            chk_outs($sformatf("v%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].es, tbl[i].ec, tbl[i].er);
        end

        // asynchronous reset in the middle of a pop
        drive(1, 32'h30, 2, 0, 4'b0000);
        tick();
        drive(1, 32'h31, 1, 0, 4'b1111);
        tick();
        chk_outs("pre_rst", 1, 32'h31, 1, 1, 1);
        drive(1, 32'h32, 3, 0, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 0, 0, 0, 0, 1);
        #3;
        drive(0, 0, 0, 0, 4'b0000);
        rst_n = 1'b1;
        tick();
        chk_outs("post_rst", 0, 0, 0, 0, 1);

`ifdef WB_ROUTE_STATS_EN
        chk("stat after reset", stat_cnt, 64'h0);
        drive(1, 32'h40, 1, 0, 4'b1111); tick();
        drive(1, 32'h41, 1, 0, 4'b1111); tick();
        drive(1, 32'h42, 1, 0, 4'b1111); tick();
        drive(0, 0,      0, 0, 4'b1111); tick();
        chk("stat sel1 x3", stat_cnt, {16'h0, 16'h0, 16'h3, 16'h0});
        chk("stat drained count", 64'(count), 64'h0);
        drive(1, 32'h50, 1, 0, 4'b0000); tick();
        drive(1, 32'h51, 1, 0, 4'b0000); tick();
        drive(0, 0,      0, 1, 4'b1111); tick();
        chk("stat after flush", stat_cnt, {16'h0, 16'h0, 16'h3, 16'h0});
        chk("flush count", 64'(count), 64'h0);
        drive(0, 0, 0, 0, 4'b0000); tick();
        // streaming sel-0 traffic: first edge pushes only, each later edge pops one
        drive(1, 32'h60, 0, 0, 4'b0001);
        repeat (100) @(posedge clk);
        #1;
        chk("stat sel0 partial", 64'(stat_cnt[15:0]), 64'd99);
        repeat (65445) @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 4'b0000);
        tick();
        chk("stat sel0 saturated", stat_cnt, {16'h0, 16'h0, 16'h3, 16'hFFFF});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
